// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1/8E1/8O1 framer.
// LSB first, idle high, zero idle gap between queued frames.
module uart_tx_buffered #(
    parameter int CLK_DIV    = 384,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_en,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          busy,
    output logic                          tx
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [15:0] CNT_MAX  = 16'(CLK_DIV - 1);
    localparam logic [AW:0] DEPTH    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [2:0]  LAST_STP = 3'(STOP_BITS - 1);
    localparam logic        ODD      = 1'(PARITY_ODD);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_nxt;
    logic [2:0]    state;
    logic [15:0]   cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par;
    logic          push;
    logic          pop;
    logic          bit_end;
    logic          last_stop;
    logic          line;

    assign push      = wr_en & ~full;
    assign bit_end   = (cnt == CNT_MAX);
    assign last_stop = (bit_idx == LAST_STP);
    assign busy      = (state != IDLE) | ~empty;

    // Pop when the framer can take a new byte: from idle, or on the final stop cycle
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == IDLE)
                pop = 1'b1;
            else if (state == STOP && bit_end && last_stop)
                pop = 1'b1;
        end
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + (AW + 1)'(1);
        else if (!push && pop)
            level_nxt = level - (AW + 1)'(1);
    end

    // Line level for the current state; registered into tx below
    always_comb begin
        line = 1'b1;
        unique case (state)
            START:   line = 1'b0;
            DATA:    line = shift[0];
            PARITY:  line = par;
            default: line = 1'b1;
        endcase
    end

    // FIFO storage; contents need no reset, pointers and level gate validity
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // FIFO pointers, level and registered flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == DEPTH);
            empty <= (level_nxt == '0);
        end
    end

    // Sticky overflow; a new drop wins over a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (wr_en && full)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

    // Framing state machine with per-bit baud counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
        end else begin
            tx  <= line;
            cnt <= bit_end ? '0 : cnt + 16'd1;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        par   <= (^mem[rd_ptr]) ^ ODD;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (last_stop) begin
                            bit_idx <= '0;
                            if (pop) begin
                                shift <= mem[rd_ptr];
                                par   <= (^mem[rd_ptr]) ^ ODD;
                                state <= START;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: random bursts, queue scoreboard,
// line monitor decoding frames sample by sample.
module tb_uart_tx_buffered;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int PEN     = 1;
    localparam int PODD    = 1;
    localparam int SB      = 2;
    localparam int NB      = 1 + 8 + PEN + SB;
    localparam int NS      = NB * CLK_DIV;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_en = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          busy;
    logic          tx;

    uart_tx_buffered #(
        .CLK_DIV(CLK_DIV),
        .FIFO_DEPTH(DEPTH),
        .PARITY_EN(PEN),
        .PARITY_ODD(PODD),
        .STOP_BITS(SB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .full(full),
        .empty(empty),
        .level(level),
        .overflow(overflow),
        .ovf_clr(ovf_clr),
        .busy(busy),
        .tx(tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        bit         b2b;
        int         start;
    } item_t;

    item_t expq[$];
    int    tests = 0;
    int    fails = 0;
    int    frames = 0;
    bit    ovf_m = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // Expected line samples for one frame, from the framing rules
    function automatic logic [NS-1:0] frame_of(logic [7:0] b);
        logic [NS-1:0] v;
        logic          val;
        for (int j = 0; j < NB; j++) begin
            if (j == 0)
                val = 1'b0;
            else if (j <= 8)
                val = b[j-1];
            else if (PEN != 0 && j == 9)
                val = (^b) ^ 1'(PODD);
            else
                val = 1'b1;
            for (int c = 0; c < CLK_DIV; c++)
                v[j*CLK_DIV + c] = val;
        end
        return v;
    endfunction

    // Line monitor: decodes each frame and checks it against the queue
    initial begin : mon
        int            s;
        int            es;
        int            fend;
        int            last_end;
        bit            ab;
        item_t         it;
        logic [NS-1:0] sv;
        logic [NS-1:0] ev;
        last_end = -100;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                s  = cyc;
                ab = 1'b0;
                for (int i = 0; i < NS; i++) begin
                    if (i > 0)
                        @(negedge clk);
                    if (rst_n !== 1'b1)
                        ab = 1'b1;
                    sv[i] = tx;
                end
                fend = cyc;
                if (!ab) begin
                    tests++;
                    if (expq.size() == 0) begin
                        fails++;
                        $display("FAIL frame: unexpected frame at %0d, got %h expected none",
                                 s, sv);
                    end else begin
                        it = expq.pop_front();
                        ev = frame_of(it.b);
                        es = it.b2b ? last_end + 1 : it.start;
                        if (sv !== ev || s != es) begin
                            fails++;
                            $display("FAIL frame %02h: got %h start %0d, expected %h start %0d",
                                     it.b, sv, s, ev, es);
                        end
                    end
                    frames++;
                end
                last_end = fend;
            end
        end
    end

    // Write n consecutive bytes from an idle, drained DUT and check FIFO
    // flags each cycle against an occupancy model
    task automatic burst(int n, int fixed, output int st);
        int         occ;
        int         k0;
        bit         acc;
        bit         pp;
        bit         clr;
        logic [7:0] d;
        item_t      it;
        occ = 0;
        k0  = -1;
        st  = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("level", 32'(level), 32'(occ));
                chk("full", 32'(full), 32'(occ == DEPTH));
                chk("empty", 32'(empty), 32'(occ == 0));
                chk("overflow", 32'(overflow), 32'(ovf_m));
                chk("busy", 32'(busy), 32'd1);
            end
            d       = (fixed >= 0) ? 8'(fixed >> (8 * k)) : 8'($urandom);
            clr     = (k == n - 1);
            wr_en   = 1'b1;
            wr_data = d;
            ovf_clr = clr;
            acc     = (occ < DEPTH);
            pp      = (k0 >= 0 && k == k0 + 1);
            if (acc) begin
                it.b     = d;
                it.b2b   = (k0 >= 0);
                it.start = cyc + 3;
                expq.push_back(it);
                if (k0 < 0) begin
                    k0 = k;
                    st = cyc + 3;
                end
            end
            ovf_m = !acc ? 1'b1 : (clr ? 1'b0 : ovf_m);
            occ   = occ + int'(acc) - int'(pp);
        end
        @(negedge clk);
        chk("level", 32'(level), 32'(occ));
        chk("full", 32'(full), 32'(occ == DEPTH));
        chk("empty", 32'(empty), 32'(occ == 0));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        if (ovf_m) begin
            ovf_clr = 1'b1;
            @(negedge clk);
            ovf_clr = 1'b0;
            ovf_m   = 1'b0;
            @(negedge clk);
            chk("ovf_clr", 32'(overflow), 32'd0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("drain queue", 32'(expq.size()), 32'd0);
        chk("drain tx", 32'(tx), 32'd1);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : main
        int st;
        int f0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst tx", 32'(tx), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst full", 32'(full), 32'd0);
        chk("rst level", 32'(level), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        burst(1, 'h55, st);
        drain();
        burst(2, 'h3CA5, st);
        drain();
        burst(1, 'h07, st);
        drain();
        burst(2, 'h00FF, st);
        drain();
        burst(6, -1, st);
        drain();
        for (int r = 0; r < 12; r++) begin
            burst(int'($urandom_range(1, DEPTH + 2)), -1, st);
            drain();
        end

        burst(2, -1, st);
        while (cyc < st + 17)
            @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid rst tx", 32'(tx), 32'd1);
        chk("mid rst empty", 32'(empty), 32'd1);
        chk("mid rst level", 32'(level), 32'd0);
        chk("mid rst full", 32'(full), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        expq.delete();
        ovf_m = 1'b0;
        f0 = frames;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("no residual frame", 32'(frames), 32'(f0));
        chk("post rst tx", 32'(tx), 32'd1);
        burst(1, 'h81, st);
        drain();
        chk("frame after reset", 32'(frames), 32'(f0 + 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
